hwag_coil_guard: RTL
====================

# hwag_coil_guard

Protection stage directly downstream of the HWAG coil comparators. It takes one coil request (coil14 or coil23 flip-flop output) and drives the physical ignition-coil gate, with three limits enforced:
- a maximum dwell (charge) time;
- a minimum off (blanking) time between charges;
- lock-out after any violation.

Sticky fault flags, a saturating fault counter and the last measured on-time are exported for SPI readback. One instance is placed per coil channel.

## Interface
- TW, 16: width of the dwell/blank timers and limit inputs
- FW, 8: width of the fault event counter

- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ena  in  1  channel enable; low forces IDLE and coil off, keeps faults
- req_in  in  1  coil request from the comparator flip-flop
- max_on  in  TW  maximum charge length in clk cycles; 0 = no limit
- min_off  in  TW  blanking length in clk cycles (effective value max(min_off,1))
- clr_fault  in  1  clears fault_on, fault_off and fault_cnt
- coil_out  out  1  coil gate drive, registered
- state_out  out  2  IDLE=0, CHARGE=1, BLANK=2, LOCK=3
- fault_on  out  1  sticky: dwell timeout occurred
- fault_off  out  1  sticky: request arrived during blanking
- fault_cnt  out  FW  saturating count of fault events
- on_time_out  out  TW  coil-high cycles of the last completed charge

## Operation
- State register, timer (TW), shadow limit register (TW), coil_out register, fault flags, fault counter and on_time register are all updated on clk.
- Reset, applied regardless of any other input:
  - state IDLE;
  - coil_out, fault_on, fault_off and state_out all 0;
  - fault_cnt 0 and on_time_out 0.
- ena=0, with rst low: next state IDLE and coil_out 0. The timer is cleared. Flags, counter and on_time_out hold.
- IDLE:
  - coil_out 0.
  - req_in=1 → CHARGE. coil_out=1, the timer is set to 1, and max_on is latched into the shadow register.
- CHARGE:
  - coil_out 1. The timer increments while the state remains.
  - req_in=0 → BLANK. coil_out=0, on_time_out is set to the timer value, the timer is reset, and min_off is latched into the shadow register.
  - Shadow≠0, timer==shadow and req_in=1 → LOCK. coil_out=0, on_time_out is set to shadow, fault_on is set and fault_cnt increments.
- BLANK:
  - coil_out 0. The timer counts until it reaches max(shadow,1).
  - The first cycle with req_in=1 in this state sets fault_off and increments fault_cnt, once per BLANK visit.
  - At expiry: req_in=1 → LOCK, otherwise → IDLE.
- LOCK:
  - coil_out 0.
  - req_in=0 → IDLE. A new charge therefore requires a fresh rising request.
- Shadow registers: a change of max_on or min_off takes effect only at the next entry to CHARGE or BLANK. SPI writes mid-pulse never alter the pulse in progress.
- fault_cnt:
  - +1 per fault event;
  - saturates at 2^FW−1, with no wrap.
- clr_fault in the same cycle as a new fault: the set wins. The flag ends at 1 and fault_cnt ends at 1.
- Dwell length: the timer cannot overflow, because the dwell length is bounded by max_on ≤ 2^TW−1. With max_on=0 the timer saturates at 2^TW−1 and on_time_out reports the saturated value.

## Timing
- Latency req_in→coil_out rise and fall: 1 cycle. coil_out is req_in delayed by one clock, truncated and gapped by the guard rules.
- Longest pulse: coil_out is high for exactly max_on cycles when max_on≠0.
- Off-time, counting from the clock edge where coil_out falls:
  - BLANK occupies M=max(min_off,1) cycles;
  - IDLE can sample a request at cycle M;
  - the earliest re-rise is at M+1.
- Flag and counter updates appear on the same edge as the corresponding state transition, or as the first req_in=1 cycle in BLANK.
- state_out always equals the current state register. There is no extra delay.
- rst or ena low during CHARGE: coil_out is 0 on the next edge. on_time_out is not updated.

## Test plan
- Reset behaviour:
  - Stimulus: rst held 3 cycles with req_in=1, then released with req_in=0.
  - Response: coil_out=0, state_out=0, fault_on=0, fault_off=0, fault_cnt=0, on_time_out=0.
- Normal pulse:
  - Stimulus: max_on=100, min_off=20, req_in high for 50 cycles.
  - Response: coil_out high for 50 cycles, starting 1 cycle later; on_time_out=50; no faults; state returns to IDLE 20 cycles after the fall.
- Dwell timeout:
  - Stimulus: max_on=10, req_in high for 30 cycles.
  - Response: coil_out high for exactly 10 cycles; fault_on=1; fault_cnt=1; on_time_out=10; state LOCK until req_in falls, then IDLE.
- Blanking reject:
  - Stimulus: min_off=20; req_in pulse of 5 cycles, low for 5 cycles, then high for 40 cycles.
  - Response: fault_off=1; fault_cnt=1; no second coil pulse; coil_out rises only after req_in drops and rises again.
- Counter saturation and clear:
  - Stimulus: FW=8, 300 timeouts, then clr_fault asserted in the same cycle as a timeout.
  - Response: fault_cnt=255 before the clear; after it, fault_on=1 and fault_cnt=1.
- Shadow limit:
  - Stimulus: max_on=100 at the rise, changed to 5 at cycle 20 of the pulse, req_in held high.
  - Response: coil_out stays high for 100 cycles; the next pulse is limited to 5 cycles.

Source files
------------

// File: rtl/hwag_coil_guard.sv
// Ignition-coil gate guard for one HWAG coil channel: enforces maximum dwell,
// minimum off-time and lock-out, with sticky fault flags and SPI-visible stats.
module hwag_coil_guard #(
  parameter int unsigned TW = 16,
  parameter int unsigned FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          req_in,
  input  logic [TW-1:0] max_on,
  input  logic [TW-1:0] min_off,
  input  logic          clr_fault,
  output logic          coil_out,
  output logic [1:0]    state_out,
  output logic          fault_on,
  output logic          fault_off,
  output logic [FW-1:0] fault_cnt,
  output logic [TW-1:0] on_time_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHARGE = 2'd1,
    S_BLANK  = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  localparam logic [TW-1:0] TMR_MAX = '1;
  localparam logic [FW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] shd_q, shd_d;
  logic [TW-1:0] ont_q, ont_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          coil_q, coil_d;
  logic          fon_q, fon_d;
  logic          foff_q, foff_d;
  logic          seen_q, seen_d;
  logic          set_on_c, set_off_c;
  logic [TW-1:0] blank_last_c;
  logic [FW-1:0] cnt_base_c;

  // Last timer value of a BLANK visit; a zero blanking length behaves as one cycle.
  assign blank_last_c = (shd_q == '0) ? '0 : shd_q - TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      shd_q   <= '0;
      ont_q   <= '0;
      cnt_q   <= '0;
      coil_q  <= 1'b0;
      fon_q   <= 1'b0;
      foff_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      shd_q   <= shd_d;
      ont_q   <= ont_d;
      cnt_q   <= cnt_d;
      coil_q  <= coil_d;
      fon_q   <= fon_d;
      foff_q  <= foff_d;
      seen_q  <= seen_d;
    end
  end

  // Next-state, timer, shadow limit and coil drive.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    shd_d     = shd_q;
    ont_d     = ont_q;
    coil_d    = 1'b0;
    seen_d    = seen_q;
    set_on_c  = 1'b0;
    set_off_c = 1'b0;
    if (!ena) begin
      state_d = S_IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_in) begin
            state_d = S_CHARGE;
            coil_d  = 1'b1;
            tmr_d   = TW'(1);
            shd_d   = max_on;
          end
        end
        S_CHARGE: begin
          coil_d = 1'b1;
          if (!req_in) begin
            state_d = S_BLANK;
            coil_d  = 1'b0;
            ont_d   = tmr_q;
            tmr_d   = '0;
            shd_d   = min_off;
            seen_d  = 1'b0;
          end else if ((shd_q != '0) && (tmr_q == shd_q)) begin
            state_d  = S_LOCK;
            coil_d   = 1'b0;
            ont_d    = shd_q;
            set_on_c = 1'b1;
          end else if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_BLANK: begin
          if (req_in && !seen_q) begin
            set_off_c = 1'b1;
            seen_d    = 1'b1;
          end
          if (tmr_q == blank_last_c) begin
            state_d = req_in ? S_LOCK : S_IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_LOCK: begin
          tmr_d = '0;
          if (!req_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sticky flags and saturating counter; a new fault wins over a same-cycle clear.
  always_comb begin
    cnt_base_c = clr_fault ? '0 : cnt_q;
    fon_d      = (fon_q & ~clr_fault) | set_on_c;
    foff_d     = (foff_q & ~clr_fault) | set_off_c;
    cnt_d      = cnt_base_c;
    if ((set_on_c || set_off_c) && (cnt_base_c != CNT_MAX)) begin
      cnt_d = cnt_base_c + FW'(1);
    end
  end

  assign coil_out    = coil_q;
  assign state_out   = 2'(state_q);
  assign fault_on    = fon_q;
  assign fault_off   = foff_q;
  assign fault_cnt   = cnt_q;
  assign on_time_out = ont_q;

endmodule
